// File: rtl/axis_frame_length_header_insert.sv
// Prepends a byte-serial length header (flags, length, optional original
// length) to each 8-bit AXI-Stream frame from the frame length adjuster.
// A single output register is shared by header and payload bytes.
module axis_frame_length_header_insert #(
    parameter int INCLUDE_ORIG_LENGTH = 1,
    parameter int USER_ENABLE         = 1,
    parameter int USER_WIDTH          = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_hdr_valid,
    output logic                  s_axis_hdr_ready,
    input  logic                  s_axis_hdr_pad,
    input  logic                  s_axis_hdr_truncate,
    input  logic [15:0]           s_axis_hdr_length,
    input  logic [15:0]           s_axis_hdr_original_length,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_length_mismatch,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    // Index of the final header byte: 5-byte header with original length, else 3.
    localparam logic [2:0] LAST_HDR_IDX = (INCLUDE_ORIG_LENGTH != 0) ? 3'd4 : 3'd2;

    state_t                r_state, w_state_next;
    logic [2:0]            r_idx;
    logic [15:0]           r_cnt;
    logic [15:0]           r_len;
    logic [15:0]           r_orig;
    logic                  r_pad;
    logic                  r_trunc;
    logic [7:0]            r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [USER_WIDTH-1:0] r_tuser;
    logic                  r_mismatch;

    logic                  w_load;
    logic                  w_hdr_ready;
    logic                  w_tready;
    logic                  w_hdr_acc;
    logic                  w_beat_acc;
    logic                  w_hdr_last;
    logic [7:0]            w_hdr_byte;
    logic [15:0]           w_cnt_inc;
    logic [USER_WIDTH-1:0] w_tuser_in;

    // Output register may take a new byte when empty or being drained this cycle.
    assign w_load     = !r_tvalid || m_axis_tready;
    assign w_hdr_acc  = w_hdr_ready && s_axis_hdr_valid;
    assign w_beat_acc = w_tready && s_axis_tvalid;
    assign w_hdr_last = (r_idx == LAST_HDR_IDX);
    assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_tuser_in = (USER_ENABLE != 0) ? s_axis_tuser : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_hdr_ready  = 1'b0;
        w_tready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_hdr_ready = 1'b1;
                if (s_axis_hdr_valid) w_state_next = HEADER;
            end
            HEADER: begin
                if (w_load && w_hdr_last) w_state_next = PAYLOAD;
            end
            PAYLOAD: begin
                w_tready = w_load;
                if (w_load && s_axis_tvalid && s_axis_tlast) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Header byte selected by the current header index.
    always_comb begin
        w_hdr_byte = {6'b0, r_trunc, r_pad};
        case (r_idx)
            3'd1:    w_hdr_byte = r_len[15:8];
            3'd2:    w_hdr_byte = r_len[7:0];
            3'd3:    w_hdr_byte = r_orig[15:8];
            3'd4:    w_hdr_byte = r_orig[7:0];
            default: w_hdr_byte = {6'b0, r_trunc, r_pad};
        endcase
    end

    // Header latch, byte index, payload count, output register and mismatch pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_orig     <= '0;
            r_pad      <= 1'b0;
            r_trunc    <= 1'b0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tuser    <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= 1'b0;
            if (w_hdr_acc) begin
                r_pad   <= s_axis_hdr_pad;
                r_trunc <= s_axis_hdr_truncate;
                r_len   <= s_axis_hdr_length;
                r_orig  <= s_axis_hdr_original_length;
                r_idx   <= '0;
            end
            if (r_state == HEADER && w_load) begin
                r_tdata  <= w_hdr_byte;
                r_tvalid <= 1'b1;
                r_tlast  <= 1'b0;
                r_tuser  <= '0;
                r_idx    <= r_idx + 3'd1;
                if (w_hdr_last) r_cnt <= '0;
            end else if (w_beat_acc) begin
                r_tdata  <= s_axis_tdata;
                r_tvalid <= 1'b1;
                r_tlast  <= s_axis_tlast;
                r_tuser  <= w_tuser_in;
                r_cnt    <= w_cnt_inc;
                // The frame still ends on tlast; the mismatch is only flagged.
                if (s_axis_tlast && (w_cnt_inc != r_len)) r_mismatch <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis_hdr_ready       = w_hdr_ready;
    assign s_axis_tready          = w_tready;
    assign m_axis_tdata           = r_tdata;
    assign m_axis_tvalid          = r_tvalid;
    assign m_axis_tlast           = r_tlast;
    assign m_axis_tuser           = r_tuser;
    assign status_length_mismatch = r_mismatch;
    assign busy                   = (r_state != IDLE);

endmodule

// File: tb/tb_axis_frame_length_header_insert.sv
// Directed bench: instance [1] has the 5-byte header, instance [0] the 3-byte one.
// Output beats of both go into one log queue as {tuser, tlast, tdata}.
module tb_axis_frame_length_header_insert;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mr  = 1'b1;
    logic       rnd_rdy = 1'b0;
    logic       win = 1'b0;

    logic       hv[2], hp[2], ht[2], hr[2];
    logic [15:0] hl[2], ho[2];
    logic [7:0] td[2], md[2];
    logic       tv[2], tr[2], tl[2], mv[2], ml[2], mm[2], bz[2];
    logic [0:0] tu[2], mu[2];

    int n_run = 0, n_fail = 0;
    int rd = 0, ls = 0;
    int cyc = 0, unstable = 0, mm_cnt = 0, mm_late = 0, hr_cnt = 0;
    int gap = 0, gap_n = 0, gap_bad = 0, hacc = 0, fv_lat = -1;
    logic seen_last = 1'b0, want_fv = 1'b0;
    logic hold[2], tacc[2];
    logic [9:0] hdat[2];
    logic [9:0] oq[$];
    logic [9:0] eq[$];

    always #5 clk = ~clk;

    axis_frame_length_header_insert #(.INCLUDE_ORIG_LENGTH(1), .USER_ENABLE(1), .USER_WIDTH(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_hdr_valid(hv[1]), .s_axis_hdr_ready(hr[1]), .s_axis_hdr_pad(hp[1]),
        .s_axis_hdr_truncate(ht[1]), .s_axis_hdr_length(hl[1]), .s_axis_hdr_original_length(ho[1]),
        .s_axis_tdata(td[1]), .s_axis_tvalid(tv[1]), .s_axis_tready(tr[1]), .s_axis_tlast(tl[1]),
        .s_axis_tuser(tu[1]), .m_axis_tdata(md[1]), .m_axis_tvalid(mv[1]), .m_axis_tready(mr),
        .m_axis_tlast(ml[1]), .m_axis_tuser(mu[1]), .status_length_mismatch(mm[1]), .busy(bz[1]));

    axis_frame_length_header_insert #(.INCLUDE_ORIG_LENGTH(0), .USER_ENABLE(1), .USER_WIDTH(1)) dut_short (
        .clk(clk), .rst(rst),
        .s_axis_hdr_valid(hv[0]), .s_axis_hdr_ready(hr[0]), .s_axis_hdr_pad(hp[0]),
        .s_axis_hdr_truncate(ht[0]), .s_axis_hdr_length(hl[0]), .s_axis_hdr_original_length(ho[0]),
        .s_axis_tdata(td[0]), .s_axis_tvalid(tv[0]), .s_axis_tready(tr[0]), .s_axis_tlast(tl[0]),
        .s_axis_tuser(tu[0]), .m_axis_tdata(md[0]), .m_axis_tvalid(mv[0]), .m_axis_tready(mr),
        .m_axis_tlast(ml[0]), .m_axis_tuser(mu[0]), .status_length_mismatch(mm[0]), .busy(bz[0]));

    // Sink ready: 50% random when enabled, else always ready.
    always @(posedge clk) begin
        #1;
        mr = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: log transfers, hold stability, mismatch timing, bubbles, latency.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (hold[d] && (!mv[d] || {mu[d], ml[d], md[d]} != hdat[d])) unstable++;
            hold[d] = mv[d] && !mr;
            hdat[d] = {mu[d], ml[d], md[d]};
            if (mv[d] && mr) oq.push_back({mu[d], ml[d], md[d]});
            if (mm[d]) begin
                mm_cnt++;
                if (!tacc[d]) mm_late++;
            end
            tacc[d] = tv[d] && tr[d] && tl[d];
        end
        if (win && hr[1]) hr_cnt++;
        if (win) begin
            if (mv[1]) begin
                if (seen_last) begin
                    gap_n++;
                    if (gap != 1) gap_bad++;
                    seen_last = 1'b0;
                end
                if (mr && ml[1]) begin
                    seen_last = 1'b1;
                    gap = 0;
                end
            end else if (seen_last) begin
                gap++;
            end
        end
        if (hv[1] && hr[1]) begin
            hacc = cyc;
            want_fv = 1'b1;
        end else if (want_fv && mv[1]) begin
            fv_lat = cyc - hacc;
            want_fv = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hdr(input int d, input logic p, input logic t,
                            input logic [15:0] len, input logic [15:0] orig);
        int to = 0;
        hv[d] = 1'b1; hp[d] = p; ht[d] = t; hl[d] = len; ho[d] = orig;
        @(negedge clk);
        while (!hr[d] && to < 5000) begin
            @(negedge clk);
            to++;
        end
        if (!hr[d]) chk("hdr_timeout", 32'd1, 32'd0);
        sync();
        hv[d] = 1'b0;
    endtask

    task automatic push_pay(input int d, input int n, input logic [7:0] base,
                            input logic gaps, input logic last_on);
        int to;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    tv[d] = 1'b0;
                    sync();
                end
            end
            tv[d] = 1'b1;
            td[d] = 8'(base + 8'(i));
            tl[d] = last_on && (i == n - 1);
            tu[d] = ^td[d];
            to = 0;
            @(negedge clk);
            while (!tr[d] && to < 5000) begin
                @(negedge clk);
                to++;
            end
            if (!tr[d]) chk("pay_timeout", 32'd1, 32'd0);
            sync();
        end
        tv[d] = 1'b0;
        tl[d] = 1'b0;
    endtask

    // Reference model: header bytes then payload, as {tuser, tlast, tdata}.
    task automatic exp_frame(input int d, input logic p, input logic t, input logic [15:0] len,
                             input logic [15:0] orig, input int n, input logic [7:0] base);
        logic [7:0] b;
        eq.push_back({2'b00, 6'b0, t, p});
        eq.push_back({2'b00, len[15:8]});
        eq.push_back({2'b00, len[7:0]});
        if (d == 1) begin
            eq.push_back({2'b00, orig[15:8]});
            eq.push_back({2'b00, orig[7:0]});
        end
        for (int i = 0; i < n; i++) begin
            b = 8'(base + 8'(i));
            eq.push_back({^b, (i == n - 1), b});
        end
    endtask

    task automatic drain_cmp(input string tag);
        int to = 0;
        int bad = 0;
        while ((oq.size() - rd) < eq.size() && to < 20000) begin
            @(negedge clk);
            to++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_beats"}, oq.size() - rd, eq.size());
        foreach (eq[i]) if ((rd + i) >= oq.size() || oq[rd + i] !== eq[i]) bad++;
        chk({tag, "_bytes"}, bad, 0);
        ls = rd;
        rd = oq.size();
        eq.delete();
    endtask

    task automatic run_frame(input string tag, input int d, input logic p, input logic t,
                             input logic [15:0] len, input logic [15:0] orig, input int n,
                             input logic [7:0] base, input logic gaps);
        sync();
        exp_frame(d, p, t, len, orig, n, base);
        fork
            push_hdr(d, p, t, len, orig);
            push_pay(d, n, base, gaps, 1'b1);
        join
        drain_cmp(tag);
    endtask

    initial begin
        int m0;
        int n;
        logic [15:0] o;
        for (int d = 0; d < 2; d++) begin
            hv[d] = 0; hp[d] = 0; ht[d] = 0; hl[d] = 0; ho[d] = 0;
            td[d] = 0; tv[d] = 0; tl[d] = 0; tu[d] = 0;
            hold[d] = 0; tacc[d] = 0; hdat[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", mv[1], 0);
        chk("rst_tdata", md[1], 0);
        chk("rst_tlast", ml[1], 0);
        chk("rst_tuser", mu[1], 0);
        chk("rst_mismatch", mm[1], 0);
        chk("rst_busy", bz[1], 0);
        chk("rst_hdr_ready", hr[1], 1);
        chk("rst_tready", tr[1], 0);

        // Pad frame, 5-byte header.
        m0 = mm_cnt;
        run_frame("pad", 1, 1'b1, 1'b0, 16'd64, 16'd10, 64, 8'h00, 1'b0);
        chk("pad_h0", oq[ls + 0], 10'h001);
        chk("pad_h1", oq[ls + 1], 10'h000);
        chk("pad_h2", oq[ls + 2], 10'h040);
        chk("pad_h3", oq[ls + 3], 10'h000);
        chk("pad_h4", oq[ls + 4], 10'h00A);
        chk("pad_p0", oq[ls + 5], 10'h000);
        chk("pad_plast", oq[ls + 68], 10'h13F);
        chk("pad_nomm", mm_cnt - m0, 0);
        chk("hdr_latency", fv_lat, 2);

        // Truncate frame, 3-byte header.
        run_frame("trunc", 0, 1'b0, 1'b1, 16'h0100, 16'h0203, 256, 8'h00, 1'b0);
        chk("tr_h0", oq[ls + 0], 10'h002);
        chk("tr_h1", oq[ls + 1], 10'h001);
        chk("tr_h2", oq[ls + 2], 10'h000);
        chk("tr_last", oq[ls + 258], 10'h1FF);

        // Length mismatch, short and long header length.
        m0 = mm_cnt;
        run_frame("mm4", 1, 1'b0, 1'b0, 16'd4, 16'd6, 6, 8'h10, 1'b0);
        chk("mm4_len", oq[ls + 2], 10'h004);
        chk("mm4_pulse", mm_cnt - m0, 1);
        m0 = mm_cnt;
        run_frame("mm8", 1, 1'b0, 1'b0, 16'd8, 16'd6, 6, 8'h20, 1'b0);
        chk("mm8_pulse", mm_cnt - m0, 1);
        chk("mm_timing", mm_late, 0);

        // Back-to-back: three frames presented together.
        sync();
        exp_frame(1, 1'b0, 1'b0, 16'd3, 16'd3, 3, 8'h30);
        exp_frame(1, 1'b1, 1'b0, 16'd5, 16'd9, 5, 8'h40);
        exp_frame(1, 1'b0, 1'b1, 16'd2, 16'd7, 2, 8'h50);
        win = 1'b1;
        fork
            begin
                push_hdr(1, 1'b0, 1'b0, 16'd3, 16'd3);
                push_hdr(1, 1'b1, 1'b0, 16'd5, 16'd9);
                push_hdr(1, 1'b0, 1'b1, 16'd2, 16'd7);
            end
            begin
                push_pay(1, 3, 8'h30, 1'b0, 1'b1);
                push_pay(1, 5, 8'h40, 1'b0, 1'b1);
                push_pay(1, 2, 8'h50, 1'b0, 1'b1);
            end
        join
        win = 1'b0;
        drain_cmp("b2b");
        chk("b2b_hdr_ready", hr_cnt, 3);
        chk("b2b_gaps", gap_n, 2);
        chk("b2b_gap_len", gap_bad, 0);

        // Reset mid-payload after 10 of 40 bytes.
        sync();
        fork
            push_hdr(1, 1'b0, 1'b0, 16'd40, 16'd40);
            push_pay(1, 10, 8'h60, 1'b0, 1'b0);
        join
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", mv[1], 0);
        chk("mid_rst_busy", bz[1], 0);
        chk("mid_rst_hdr_ready", hr[1], 1);
        rd = oq.size();
        m0 = mm_cnt;
        run_frame("post_rst", 1, 1'b1, 1'b0, 16'd12, 16'd12, 12, 8'hA0, 1'b0);
        chk("post_rst_nomm", mm_cnt - m0, 0);

        // Random ready/valid over 20 frames.
        rnd_rdy = 1'b1;
        m0 = mm_cnt;
        for (int f = 0; f < 20; f++) begin
            n = $urandom_range(1, 300);
            o = 16'($urandom_range(0, 65535));
            run_frame("rnd", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'(n), o, n, 8'($urandom_range(0, 255)), 1'b1);
        end
        rnd_rdy = 1'b0;
        chk("rnd_nomm", mm_cnt - m0, 0);
        chk("hold_stable", unstable, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
